cmd_sequencer: RTL and testbench

Command sequencer between the UART command receiver and the MazeRunner motion datapath. Accepts one 16-bit command at a time from the bluetooth/UART wrapper. Decodes calibrate, heading, move and solve opcodes, pulses the matching start strobe into the datapath, and waits for that engine's completion. Returns a one-byte response: positive ack 0xA5, or negative ack 0x5A on an illegal opcode or watchdog timeout.

---
 rtl/cmd_sequencer_pkg.sv | 26 ++
 rtl/cmd_sequencer_if.sv | 20 ++
 rtl/cmd_sequencer_wdog.sv | 30 +++
 rtl/cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cmd_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cmd_sequencer_pkg.sv
// rtl/cmd_sequencer_pkg.sv - shared opcodes, FSM states and constants for cmd_sequencer
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    OP_CAL   = 3'b000,
    OP_HDNG  = 3'b001,
    OP_MV    = 3'b010,
    OP_SOLVE = 3'b011
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    HDNG,
    MOVE,
    SOLVE,
    RESP
  } state_t;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;

  localparam int WDOG_W_FAST = 16;
  localparam int WDOG_W_SLOW = 26;

endpackage

// File: rtl/cmd_sequencer_if.sv
// rtl/cmd_sequencer_if.sv - command/response handshake between UART wrapper and sequencer
interface cmd_sequencer_if;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    output cmd, cmd_rdy,
    input  clr_cmd_rdy, send_resp, resp
  );

  modport slave (
    input  cmd, cmd_rdy,
    output clr_cmd_rdy, send_resp, resp
  );

endinterface

// File: rtl/cmd_sequencer_wdog.sv
// rtl/cmd_sequencer_wdog.sv - clear/enable watchdog counter with registered expiry flag
module cmd_wdog #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [W-1:0] LAST_M1 = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] r_cnt;
  logic         r_expired;

  // Flag is set one count early so it is visible during the 2^W-th enabled cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_M1) r_expired <= 1'b1;
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - decodes UART commands, strobes the motion engines, returns ACK/NAK
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  cmd_sequencer_if.slave    bus,
  output logic              strt_cal,
  input  logic              cal_done,
  output logic [11:0]       dsrd_hdng,
  output logic              strt_hdng,
  output logic              strt_mv,
  output logic              stp_lft,
  output logic              stp_rght,
  input  logic              mv_cmplt,
  output logic              solve_en,
  output logic              lft_afnty,
  input  logic              sol_cmplt,
  output logic              busy
);

  localparam int WD_W = FAST_SIM ? WDOG_W_FAST : WDOG_W_SLOW;

  state_t      r_state, w_state_n;
  logic        r_clr, r_strt_cal, r_strt_hdng, r_strt_mv, r_send;
  logic        r_stp_lft, r_stp_rght, r_solve_en, r_lft_afnty;
  logic [11:0] r_hdng;
  logic [7:0]  r_resp;

  logic        w_clr_n, w_strt_cal_n, w_strt_hdng_n, w_strt_mv_n, w_send_n;
  logic        w_stp_lft_n, w_stp_rght_n, w_solve_en_n, w_lft_afnty_n;
  logic [11:0] w_hdng_n;
  logic [7:0]  w_resp_n;
  logic        w_wd_clr, w_wd_en, w_wd_expired, w_done;
  opcode_t     w_op;
  logic        w_unused_bits;

  assign w_op          = opcode_t'(bus.cmd[15:13]);
  assign w_unused_bits = bus.cmd[12];

  cmd_wdog #(.W(WD_W)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n     = r_state;
    w_clr_n       = 1'b0;
    w_strt_cal_n  = 1'b0;
    w_strt_hdng_n = 1'b0;
    w_strt_mv_n   = 1'b0;
    w_send_n      = 1'b0;
    w_resp_n      = r_resp;
    w_hdng_n      = r_hdng;
    w_stp_lft_n   = r_stp_lft;
    w_stp_rght_n  = r_stp_rght;
    w_solve_en_n  = r_solve_en;
    w_lft_afnty_n = r_lft_afnty;
    w_wd_clr      = 1'b0;
    w_wd_en       = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cmd_rdy) begin
          w_clr_n  = 1'b1;
          w_wd_clr = 1'b1;
          case (w_op)
            OP_CAL: begin
              w_state_n    = CAL;
              w_strt_cal_n = 1'b1;
            end
            OP_HDNG: begin
              w_state_n     = HDNG;
              w_hdng_n      = bus.cmd[11:0];
              w_strt_hdng_n = 1'b1;
            end
            OP_MV: begin
              w_state_n    = MOVE;
              w_stp_lft_n  = bus.cmd[1];
              w_stp_rght_n = bus.cmd[0];
              w_strt_mv_n  = 1'b1;
            end
            OP_SOLVE: begin
              w_state_n     = SOLVE;
              w_lft_afnty_n = bus.cmd[0];
              w_solve_en_n  = 1'b1;
            end
            default: begin
              w_state_n = RESP;
              w_send_n  = 1'b1;
              w_resp_n  = NAK;
            end
          endcase
        end
      end
      CAL, HDNG, MOVE, SOLVE: begin
        w_wd_en = 1'b1;
        case (r_state)
          CAL:     w_done = cal_done;
          SOLVE:   w_done = sol_cmplt;
          default: w_done = mv_cmplt;
        endcase
        // Completion is tested first so it beats a simultaneous watchdog expiry.
        if (w_done || w_wd_expired) begin
          w_state_n    = RESP;
          w_send_n     = 1'b1;
          w_resp_n     = w_done ? ACK : NAK;
          w_solve_en_n = 1'b0;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr       <= 1'b0;
      r_strt_cal  <= 1'b0;
      r_strt_hdng <= 1'b0;
      r_strt_mv   <= 1'b0;
      r_send      <= 1'b0;
      r_resp      <= 8'h00;
      r_hdng      <= 12'h000;
      r_stp_lft   <= 1'b0;
      r_stp_rght  <= 1'b0;
      r_solve_en  <= 1'b0;
      r_lft_afnty <= 1'b0;
    end else begin
      r_clr       <= w_clr_n;
      r_strt_cal  <= w_strt_cal_n;
      r_strt_hdng <= w_strt_hdng_n;
      r_strt_mv   <= w_strt_mv_n;
      r_send      <= w_send_n;
      r_resp      <= w_resp_n;
      r_hdng      <= w_hdng_n;
      r_stp_lft   <= w_stp_lft_n;
      r_stp_rght  <= w_stp_rght_n;
      r_solve_en  <= w_solve_en_n;
      r_lft_afnty <= w_lft_afnty_n;
    end
  end

  assign bus.clr_cmd_rdy = r_clr;
  assign bus.send_resp   = r_send;
  assign bus.resp        = r_resp;
  assign strt_cal        = r_strt_cal;
  assign strt_hdng       = r_strt_hdng;
  assign strt_mv         = r_strt_mv;
  assign dsrd_hdng       = r_hdng;
  assign stp_lft         = r_stp_lft;
  assign stp_rght        = r_stp_rght;
  assign solve_en        = r_solve_en;
  assign lft_afnty       = r_lft_afnty;
  assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb/tb_cmd_sequencer.sv - directed vector bench for cmd_sequencer
module tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        strt_cal, strt_hdng, strt_mv, stp_lft, stp_rght, solve_en, lft_afnty, busy;
  logic        cal_done, mv_cmplt, sol_cmplt;
  logic [11:0] dsrd_hdng;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_sequencer_if bus ();

  cmd_sequencer #(.FAST_SIM(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .strt_cal  (strt_cal),
    .cal_done  (cal_done),
    .dsrd_hdng (dsrd_hdng),
    .strt_hdng (strt_hdng),
    .strt_mv   (strt_mv),
    .stp_lft   (stp_lft),
    .stp_rght  (stp_rght),
    .mv_cmplt  (mv_cmplt),
    .solve_en  (solve_en),
    .lft_afnty (lft_afnty),
    .sol_cmplt (sol_cmplt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cmd;
    logic [7:0]  dly;
    logic        illegal;
    logic [2:0]  strb;
    logic [11:0] hdng;
    logic        sl;
    logic        sr;
    logic        af;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic quiet;
    @(negedge clk);
    bus.cmd     = v.cmd;
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    chk("clr_cmd_rdy", bus.clr_cmd_rdy, 1);
    chk("strobes", {strt_cal, strt_hdng, strt_mv}, v.strb);
    chk("busy_accept", busy, 1);
    bus.cmd_rdy = 1'b0;
    if (v.illegal) begin
      chk("nak_pulse", bus.send_resp, 1);
      chk("nak_byte", bus.resp, 8'h5A);
    end else begin
      chk("dsrd_hdng", dsrd_hdng, v.hdng);
      chk("stp_bits", {stp_lft, stp_rght}, {v.sl, v.sr});
      chk("lft_afnty", lft_afnty, v.af);
      chk("solve_en_on", solve_en, (v.cmd[15:13] == 3'b011));
      quiet = 1'b1;
      for (int i = 0; i < int'(v.dly); i++) begin
        @(negedge clk);
        if (bus.send_resp || bus.clr_cmd_rdy || strt_cal || strt_hdng || strt_mv) quiet = 1'b0;
      end
      chk("quiet_wait", quiet, 1);
      case (v.cmd[15:13])
        3'b000:         cal_done  = 1'b1;
        3'b001, 3'b010: mv_cmplt  = 1'b1;
        default:        sol_cmplt = 1'b1;
      endcase
      @(negedge clk);
      cal_done  = 1'b0;
      mv_cmplt  = 1'b0;
      sol_cmplt = 1'b0;
      chk("ack_pulse", bus.send_resp, 1);
      chk("ack_byte", bus.resp, 8'hA5);
      chk("solve_en_off", solve_en, 0);
    end
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("resp_single", bus.send_resp, 0);
    chk("resp_held", bus.resp, v.illegal ? 8'h5A : 8'hA5);
  endtask

  initial begin
    logic quiet;
    int   n;

    vecs[0] = '{16'h0000, 8'd20, 1'b0, 3'b100, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h23FF, 8'd3,  1'b0, 3'b010, 12'h3FF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h2000, 8'd0,  1'b0, 3'b010, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h4002, 8'd5,  1'b0, 3'b001, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h6001, 8'd4,  1'b0, 3'b000, 12'h000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'hE000, 8'd0,  1'b1, 3'b000, 12'h000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h8123, 8'd0,  1'b1, 3'b000, 12'h000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h4001, 8'd2,  1'b0, 3'b001, 12'h000, 1'b0, 1'b1, 1'b1};

    rst         = 1'b1;
    bus.cmd     = 16'h0000;
    bus.cmd_rdy = 1'b0;
    cal_done    = 1'b0;
    mv_cmplt    = 1'b0;
    sol_cmplt   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulses", {bus.clr_cmd_rdy, bus.send_resp, strt_cal, strt_hdng, strt_mv}, 0);
    chk("rst_fields", {dsrd_hdng, stp_lft, stp_rght, solve_en, lft_afnty, busy}, 0);
    chk("rst_resp", bus.resp, 8'h00);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Second command raised while busy must wait for IDLE.
    @(negedge clk);
    bus.cmd     = 16'h4002;
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    chk("busyhold_clr", bus.clr_cmd_rdy, 1);
    chk("busyhold_mv", strt_mv, 1);
    bus.cmd_rdy = 1'b0;
    @(negedge clk);
    bus.cmd     = 16'h2155;
    bus.cmd_rdy = 1'b1;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.clr_cmd_rdy || strt_hdng) quiet = 1'b0;
    end
    chk("busyhold_not_cleared", quiet, 1);
    mv_cmplt = 1'b1;
    @(negedge clk);
    mv_cmplt = 1'b0;
    chk("busyhold_ack", {bus.send_resp, bus.resp}, {1'b1, 8'hA5});
    chk("busyhold_clr_resp", bus.clr_cmd_rdy, 0);
    @(negedge clk);
    chk("busyhold_idle", {busy, bus.clr_cmd_rdy}, 2'b00);
    @(negedge clk);
    chk("busyhold_accept", {bus.clr_cmd_rdy, strt_hdng}, 2'b11);
    chk("busyhold_hdng", dsrd_hdng, 12'h155);
    bus.cmd_rdy = 1'b0;
    mv_cmplt = 1'b1;
    @(negedge clk);
    mv_cmplt = 1'b0;
    chk("busyhold_ack2", {bus.send_resp, bus.resp}, {1'b1, 8'hA5});
    @(negedge clk);

    // Watchdog: move that never completes.
    @(negedge clk);
    bus.cmd     = 16'h4001;
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    chk("wdog_clr", bus.clr_cmd_rdy, 1);
    bus.cmd_rdy = 1'b0;
    n = 0;
    while (!bus.send_resp && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_cycles", n, 65536);
    chk("wdog_nak", bus.resp, 8'h5A);
    chk("wdog_stp", {stp_lft, stp_rght}, 2'b01);
    @(negedge clk);
    chk("wdog_idle", busy, 0);

    // Reset in the middle of a solve.
    @(negedge clk);
    bus.cmd     = 16'h6000;
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    chk("midrst_solve_en", solve_en, 1);
    bus.cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", {solve_en, busy, bus.send_resp}, 3'b000);
    chk("midrst_hdng", dsrd_hdng, 12'h000);
    rst       = 1'b0;
    sol_cmplt = 1'b1;
    @(negedge clk);
    sol_cmplt = 1'b0;
    chk("midrst_late_cmplt", {bus.send_resp, busy}, 2'b00);
    @(negedge clk);
    chk("midrst_no_resp", bus.send_resp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
